// File: rtl/usb_ep_buf_arb_pkg.sv
// ---------------------------------------------------------------------------
// usb_ep_buf_arb_pkg
// Shared definitions for the USB-side endpoint buffer arbiter:
//   - default buffer address / read / write widths
//   - default starvation bound and register-bus data width
//   - bus-side FSM state encoding
// ---------------------------------------------------------------------------
package usb_ep_buf_arb_pkg;

  localparam int unsigned DEF_AW         = 11;
  localparam int unsigned DEF_RW         = 8;
  localparam int unsigned DEF_WW         = 8;
  localparam int unsigned DEF_STARVE_MAX = 15;
  localparam int unsigned BUS_DW         = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_ACK     = 3'd4
  } bus_st_e;

endpackage

// File: rtl/usb_ep_buf_arb_starve.sv
// ---------------------------------------------------------------------------
// usb_ep_buf_arb_starve
// Wait counter for the bus side of the arbiter. Counts cycles in which a
// pending bus request loses to the core; once the count reaches STARVE_MAX
// the matching force output is raised for that cycle, which blocks the core
// and grants the bus. The counter clears whenever the bus is not being denied
// (grant, abort, or no pending request).
//
// Ports:
//   i_clk, i_rst        clock, async active-high reset
//   i_rd_wait           bus FSM in RD_REQ with bus_cyc high
//   i_wr_wait           bus FSM in WR_REQ with bus_cyc high
//   i_core_rd_req       core TX-buffer read request
//   i_core_wr_req       core RX-buffer write request
//   o_force_rd          force bus grant on the read port this cycle
//   o_force_wr          force bus grant on the write port this cycle
// ---------------------------------------------------------------------------
module usb_ep_buf_arb_starve #(
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rd_wait,
  input  logic i_wr_wait,
  input  logic i_core_rd_req,
  input  logic i_core_wr_req,
  output logic o_force_rd,
  output logic o_force_wr
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_max;
  logic          w_denied;

  assign w_at_max   = (r_cnt == CW'(STARVE_MAX));
  assign o_force_rd = i_rd_wait & w_at_max;
  assign o_force_wr = i_wr_wait & w_at_max;

  // Only one of the two wait conditions can be true at a time (single FSM).
  assign w_denied = (i_rd_wait & i_core_rd_req & ~o_force_rd) |
                    (i_wr_wait & i_core_wr_req & ~o_force_wr);

  // Wait counter: counts consecutive denied cycles, clears otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= {CW{1'b0}};
    end else if (w_denied) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= {CW{1'b0}};
    end
  end

endmodule

// File: rtl/usb_ep_buf_arb.sv
// ---------------------------------------------------------------------------
// usb_ep_buf_arb
// Shares the USB side of the endpoint buffers (TX-buffer read port, RX-buffer
// write port) between the USB core and the bridge's 16-bit register bus.
// The two ports are arbitrated independently. The core has strict priority;
// the bus is served in idle slots through a small FSM.
//
// Optional feature (macro USB_EP_BUF_ARB_STARVE_EN): starvation guard that
// forces a bus grant after STARVE_MAX denied cycles. Without the macro the
// force signals are tied low and the bus may wait indefinitely.
//
// Ports:
//   i_clk, i_rst                          USB clock, async active-high reset
//   i_core_rd_req/_addr, o_core_rd_rdy    core TX-buffer read request
//   o_core_rd_data, o_core_rd_vld         read data, one cycle after accept
//   i_core_wr_req/_addr/_data, o_core_wr_rdy  core RX-buffer write
//   i_bus_addr/_wdata/_cyc/_we            register-bus request
//   o_bus_rdata, o_bus_ack                register-bus response
//   o_ram_raddr, o_ram_ren, i_ram_rdata   TX-buffer read port
//   o_ram_waddr, o_ram_wdata, o_ram_we    RX-buffer write port
// ---------------------------------------------------------------------------
module usb_ep_buf_arb
  import usb_ep_buf_arb_pkg::*;
#(
  parameter int unsigned AW         = DEF_AW,
  parameter int unsigned RW         = DEF_RW,
  parameter int unsigned WW         = DEF_WW,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_core_rd_req,
  input  logic [AW-1:0] i_core_rd_addr,
  output logic          o_core_rd_rdy,
  output logic [RW-1:0] o_core_rd_data,
  output logic          o_core_rd_vld,
  input  logic          i_core_wr_req,
  input  logic [AW-1:0] i_core_wr_addr,
  input  logic [WW-1:0] i_core_wr_data,
  output logic          o_core_wr_rdy,
  input  logic [AW-1:0] i_bus_addr,
  input  logic [15:0]   i_bus_wdata,
  output logic [15:0]   o_bus_rdata,
  input  logic          i_bus_cyc,
  input  logic          i_bus_we,
  output logic          o_bus_ack,
  output logic [AW-1:0] o_ram_raddr,
  output logic          o_ram_ren,
  input  logic [RW-1:0] i_ram_rdata,
  output logic [AW-1:0] o_ram_waddr,
  output logic [WW-1:0] o_ram_wdata,
  output logic          o_ram_we
);

  bus_st_e     r_state;
  bus_st_e     w_state_nxt;
  logic        r_core_rd_vld;
  logic [15:0] r_bus_rdata;

  logic w_force_rd;
  logic w_force_wr;
  logic w_rd_wait;
  logic w_wr_wait;
  logic w_core_rd_acc;
  logic w_core_wr_acc;
  logic w_bus_rd_gnt;
  logic w_bus_wr_gnt;
  logic w_unused_wdata;

  // Upper bus write-data bits beyond WW never reach the RX buffer.
  assign w_unused_wdata = ^i_bus_wdata;

  // A bus request is only live while bus_cyc is held; dropping it aborts.
  assign w_rd_wait = (r_state == ST_RD_REQ) & i_bus_cyc;
  assign w_wr_wait = (r_state == ST_WR_REQ) & i_bus_cyc;

`ifdef USB_EP_BUF_ARB_STARVE_EN
  usb_ep_buf_arb_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_rd_wait     (w_rd_wait),
    .i_wr_wait     (w_wr_wait),
    .i_core_rd_req (i_core_rd_req),
    .i_core_wr_req (i_core_wr_req),
    .o_force_rd    (w_force_rd),
    .o_force_wr    (w_force_wr)
  );
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (STARVE_MAX == 32'd0);
  assign w_force_rd   = 1'b0;
  assign w_force_wr   = 1'b0;
`endif

  // Ready is also held low during reset so no RAM enable can leak out.
  assign o_core_rd_rdy = ~w_force_rd & ~i_rst;
  assign o_core_wr_rdy = ~w_force_wr & ~i_rst;
  assign w_core_rd_acc = i_core_rd_req & o_core_rd_rdy;
  assign w_core_wr_acc = i_core_wr_req & o_core_wr_rdy;

  // Grants are mutually exclusive with core accepts: a grant needs either no
  // core request or a force, and a force drops core ready.
  assign w_bus_rd_gnt = w_rd_wait & (~i_core_rd_req | w_force_rd);
  assign w_bus_wr_gnt = w_wr_wait & (~i_core_wr_req | w_force_wr);

  assign o_core_rd_vld  = r_core_rd_vld;
  assign o_core_rd_data = r_core_rd_vld ? i_ram_rdata : {RW{1'b0}};
  assign o_bus_rdata    = r_bus_rdata;

  // Bus FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bus FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_bus_cyc) begin
          w_state_nxt = i_bus_we ? ST_WR_REQ : ST_RD_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        if (!i_bus_cyc) begin
          w_state_nxt = ST_IDLE;
        end else if (w_bus_rd_gnt) begin
          w_state_nxt = ST_RD_DATA;
        end else begin
          w_state_nxt = ST_RD_REQ;
        end
      end
      ST_RD_DATA: w_state_nxt = ST_ACK;
      ST_WR_REQ: begin
        if (!i_bus_cyc) begin
          w_state_nxt = ST_IDLE;
        end else if (w_bus_wr_gnt) begin
          w_state_nxt = ST_ACK;
        end else begin
          w_state_nxt = ST_WR_REQ;
        end
      end
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs and RAM port muxes: an accepted core access owns its port,
  // otherwise a granted bus access; idle ports drive zeros.
  always_comb begin
    o_bus_ack   = (r_state == ST_ACK);
    o_ram_ren   = 1'b0;
    o_ram_raddr = {AW{1'b0}};
    o_ram_we    = 1'b0;
    o_ram_waddr = {AW{1'b0}};
    o_ram_wdata = {WW{1'b0}};
    if (w_core_rd_acc) begin
      o_ram_ren   = 1'b1;
      o_ram_raddr = i_core_rd_addr;
    end else if (w_bus_rd_gnt) begin
      o_ram_ren   = 1'b1;
      o_ram_raddr = i_bus_addr;
    end else begin
      o_ram_ren   = 1'b0;
      o_ram_raddr = {AW{1'b0}};
    end
    if (w_core_wr_acc) begin
      o_ram_we    = 1'b1;
      o_ram_waddr = i_core_wr_addr;
      o_ram_wdata = i_core_wr_data;
    end else if (w_bus_wr_gnt) begin
      o_ram_we    = 1'b1;
      o_ram_waddr = i_bus_addr;
      o_ram_wdata = i_bus_wdata[WW-1:0];
    end else begin
      o_ram_we    = 1'b0;
      o_ram_waddr = {AW{1'b0}};
      o_ram_wdata = {WW{1'b0}};
    end
  end

  // Core read-data valid: the buffer returns data one cycle after accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_core_rd_vld <= 1'b0;
    end else begin
      r_core_rd_vld <= w_core_rd_acc;
    end
  end

  // Bus read data: captured from the buffer in RD_DATA, held for the ack.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bus_rdata <= 16'h0000;
    end else if (r_state == ST_RD_DATA) begin
      r_bus_rdata <= 16'(i_ram_rdata);
    end else begin
      r_bus_rdata <= r_bus_rdata;
    end
  end

endmodule

// File: tb/tb_usb_ep_buf_arb.sv
// ---------------------------------------------------------------------------
// tb_usb_ep_buf_arb
// Self-checking bench for usb_ep_buf_arb: a per-cycle vector table plus
// hand-written sequences for starvation and reset during a bus read.
// The TX buffer is modelled as a synchronous RAM returning addr[7:0]^8'h7C.
// ---------------------------------------------------------------------------
module tb_usb_ep_buf_arb;

  localparam int AW = 11;
  localparam int RW = 8;
  localparam int WW = 8;
  localparam int STARVE_MAX = 15;
  localparam int NV = 34;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          core_rd_req;
  logic [AW-1:0] core_rd_addr;
  logic          core_rd_rdy;
  logic [RW-1:0] core_rd_data;
  logic          core_rd_vld;
  logic          core_wr_req;
  logic [AW-1:0] core_wr_addr;
  logic [WW-1:0] core_wr_data;
  logic          core_wr_rdy;
  logic [AW-1:0] bus_addr;
  logic [15:0]   bus_wdata;
  logic [15:0]   bus_rdata;
  logic          bus_cyc;
  logic          bus_we;
  logic          bus_ack;
  logic [AW-1:0] ram_raddr;
  logic          ram_ren;
  logic [RW-1:0] ram_q = 8'h00;
  logic [AW-1:0] ram_waddr;
  logic [WW-1:0] ram_wdata;
  logic          ram_we;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic          cr_req;
    logic [AW-1:0] cr_addr;
    logic          cw_req;
    logic [AW-1:0] cw_addr;
    logic [WW-1:0] cw_data;
    logic          cyc;
    logic          we;
    logic [AW-1:0] baddr;
    logic [15:0]   bwdata;
    logic          x_rrdy;
    logic          x_wrdy;
    logic          x_ren;
    logic [AW-1:0] x_raddr;
    logic          x_we;
    logic [AW-1:0] x_waddr;
    logic [WW-1:0] x_wdata;
    logic          x_ack;
    logic          x_vld;
    logic [RW-1:0] x_rdata;
    logic [15:0]   x_brdata;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_val(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h7C;
  endfunction

  always @(posedge clk) begin
    if (ram_ren) ram_q <= mem_val(ram_raddr);
  end

  usb_ep_buf_arb dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_core_rd_req  (core_rd_req),
    .i_core_rd_addr (core_rd_addr),
    .o_core_rd_rdy  (core_rd_rdy),
    .o_core_rd_data (core_rd_data),
    .o_core_rd_vld  (core_rd_vld),
    .i_core_wr_req  (core_wr_req),
    .i_core_wr_addr (core_wr_addr),
    .i_core_wr_data (core_wr_data),
    .o_core_wr_rdy  (core_wr_rdy),
    .i_bus_addr     (bus_addr),
    .i_bus_wdata    (bus_wdata),
    .o_bus_rdata    (bus_rdata),
    .i_bus_cyc      (bus_cyc),
    .i_bus_we       (bus_we),
    .o_bus_ack      (bus_ack),
    .o_ram_raddr    (ram_raddr),
    .o_ram_ren      (ram_ren),
    .i_ram_rdata    (ram_q),
    .o_ram_waddr    (ram_waddr),
    .o_ram_wdata    (ram_wdata),
    .o_ram_we       (ram_we)
  );

  function automatic logic [59:0] outs_all();
    return {core_rd_rdy, core_wr_rdy, ram_ren, ram_raddr, ram_we, ram_waddr,
            ram_wdata, bus_ack, core_rd_vld, core_rd_data, bus_rdata};
  endfunction

  // Fields that are don't-care while their enable is low are zeroed.
  function automatic logic [59:0] outs_masked();
    return {core_rd_rdy, core_wr_rdy, ram_ren, (ram_ren ? ram_raddr : 11'h000),
            ram_we, (ram_we ? ram_waddr : 11'h000), (ram_we ? ram_wdata : 8'h00),
            bus_ack, core_rd_vld, (core_rd_vld ? core_rd_data : 8'h00), bus_rdata};
  endfunction

  function automatic logic [59:0] exp_pack(input vec_t v);
    return {v.x_rrdy, v.x_wrdy, v.x_ren, v.x_raddr, v.x_we, v.x_waddr,
            v.x_wdata, v.x_ack, v.x_vld, v.x_rdata, v.x_brdata};
  endfunction

  task automatic chk(input string name, input logic [59:0] act, input logic [59:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic drive_idle();
    core_rd_req = 1'b0; core_rd_addr = 11'h000;
    core_wr_req = 1'b0; core_wr_addr = 11'h000; core_wr_data = 8'h00;
    bus_cyc = 1'b0; bus_we = 1'b0; bus_addr = 11'h000; bus_wdata = 16'h0000;
  endtask

  task automatic drive(input vec_t v);
    core_rd_req = v.cr_req; core_rd_addr = v.cr_addr;
    core_wr_req = v.cw_req; core_wr_addr = v.cw_addr; core_wr_data = v.cw_data;
    bus_cyc = v.cyc; bus_we = v.we; bus_addr = v.baddr; bus_wdata = v.bwdata;
  endtask

  int rdy_low, gnt_cyc, ack_cyc, ren_cyc, n_ack, n_ren;
  logic [15:0] got_rdata;

  initial begin
    // inputs: cr_req cr_addr cw_req cw_addr cw_data cyc we baddr bwdata
    // expect: rrdy wrdy ren raddr we waddr wdata ack vld rdata brdata
    // bus write 0x012 <- 0x00A5
    vecs[0]  = '{1'b0,11'h000,1'b0,11'h000,8'h00,1'b1,1'b1,11'h012,16'h00A5, 1'b1,1'b1,1'b0,11'h000,1'b0,11'h000,8'h00,1'b0,1'b0,8'h00,16'h0000};
    vecs[1]  = '{1'b0,11'h000,1'b0,11'h000,8'h00,1'b1,1'b1,11'h012,16'h00A5, 1'b1,1'b1,1'b0,11'h000,1'b1,11'h012,8'hA5,1'b0,1'b0,8'h00,16'h0000};
    vecs[2]  = '{1'b0,11'h000,1'b0,11'h000,8'h00,1'b1,1'b1,11'h012,16'h00A5, 1'b1,1'b1,1'b0,11'h000,1'b0,11'h000,8'h00,1'b1,1'b0,8'h00,16'h0000};
    vecs[3]  = '{1'b0,11'h000,1'b0,11'h000,8'h00,1'b0,1'b0,11'h000,16'h0000, 1'b1,1'b1,1'b0,11'h000,1'b0,11'h000,8'h00,1'b0,1'b0,8'h00,16'h0000};
    // bus read 0x040 -> 0x3C
    vecs[4]  = '{1'b0,11'h000,1'b0,11'h000,8'h00,1'b1,1'b0,11'h040,16'h0000, 1'b1,1'b1,1'b0,11'h000,1'b0,11'h000,8'h00,1'b0,1'b0,8'h00,16'h0000};
    vecs[5]  = '{1'b0,11'h000,1'b0,11'h000,8'h00,1'b1,1'b0,11'h040,16'h0000, 1'b1,1'b1,1'b1,11'h040,1'b0,11'h000,8'h00,1'b0,1'b0,8'h00,16'h0000};
    vecs[6]  = '{1'b0,11'h000,1'b0,11'h000,8'h00,1'b1,1'b0,11'h040,16'h0000, 1'b1,1'b1,1'b0,11'h000,1'b0,11'h000,8'h00,1'b0,1'b0,8'h00,16'h0000};
    vecs[7]  = '{1'b0,11'h000,1'b0,11'h000,8'h00,1'b1,1'b0,11'h040,16'h0000, 1'b1,1'b1,1'b0,11'h000,1'b0,11'h000,8'h00,1'b1,1'b0,8'h00,16'h003C};
    vecs[8]  = '{1'b0,11'h000,1'b0,11'h000,8'h00,1'b0,1'b0,11'h000,16'h0000, 1'b1,1'b1,1'b0,11'h000,1'b0,11'h000,8'h00,1'b0,1'b0,8'h00,16'h003C};
    // core reads 5,6,7 back to back
    vecs[9]  = '{1'b1,11'h005,1'b0,11'h000,8'h00,1'b0,1'b0,11'h000,16'h0000, 1'b1,1'b1,1'b1,11'h005,1'b0,11'h000,8'h00,1'b0,1'b0,8'h00,16'h003C};
    vecs[10] = '{1'b1,11'h006,1'b0,11'h000,8'h00,1'b0,1'b0,11'h000,16'h0000, 1'b1,1'b1,1'b1,11'h006,1'b0,11'h000,8'h00,1'b0,1'b1,8'h79,16'h003C};
    vecs[11] = '{1'b1,11'h007,1'b0,11'h000,8'h00,1'b0,1'b0,11'h000,16'h0000, 1'b1,1'b1,1'b1,11'h007,1'b0,11'h000,8'h00,1'b0,1'b1,8'h7A,16'h003C};
    vecs[12] = '{1'b0,11'h000,1'b0,11'h000,8'h00,1'b0,1'b0,11'h000,16'h0000, 1'b1,1'b1,1'b0,11'h000,1'b0,11'h000,8'h00,1'b0,1'b1,8'h7B,16'h003C};
    vecs[13] = '{1'b0,11'h000,1'b0,11'h000,8'h00,1'b0,1'b0,11'h000,16'h0000, 1'b1,1'b1,1'b0,11'h000,1'b0,11'h000,8'h00,1'b0,1'b0,8'h00,16'h003C};
    // core write alone, then bus read alongside core writes
    vecs[14] = '{1'b0,11'h000,1'b1,11'h100,8'h33,1'b0,1'b0,11'h000,16'h0000, 1'b1,1'b1,1'b0,11'h000,1'b1,11'h100,8'h33,1'b0,1'b0,8'h00,16'h003C};
    vecs[15] = '{1'b0,11'h000,1'b1,11'h101,8'h44,1'b1,1'b0,11'h007,16'h0000, 1'b1,1'b1,1'b0,11'h000,1'b1,11'h101,8'h44,1'b0,1'b0,8'h00,16'h003C};
    vecs[16] = '{1'b0,11'h000,1'b1,11'h102,8'h55,1'b1,1'b0,11'h007,16'h0000, 1'b1,1'b1,1'b1,11'h007,1'b1,11'h102,8'h55,1'b0,1'b0,8'h00,16'h003C};
    vecs[17] = '{1'b0,11'h000,1'b1,11'h103,8'h66,1'b1,1'b0,11'h007,16'h0000, 1'b1,1'b1,1'b0,11'h000,1'b1,11'h103,8'h66,1'b0,1'b0,8'h00,16'h003C};
    vecs[18] = '{1'b0,11'h000,1'b0,11'h000,8'h00,1'b1,1'b0,11'h007,16'h0000, 1'b1,1'b1,1'b0,11'h000,1'b0,11'h000,8'h00,1'b1,1'b0,8'h00,16'h007B};
    vecs[19] = '{1'b0,11'h000,1'b0,11'h000,8'h00,1'b0,1'b0,11'h000,16'h0000, 1'b1,1'b1,1'b0,11'h000,1'b0,11'h000,8'h00,1'b0,1'b0,8'h00,16'h007B};
    // bus read 0x020 contends with core reads 0x030/0x031
    vecs[20] = '{1'b1,11'h030,1'b0,11'h000,8'h00,1'b1,1'b0,11'h020,16'h0000, 1'b1,1'b1,1'b1,11'h030,1'b0,11'h000,8'h00,1'b0,1'b0,8'h00,16'h007B};
    vecs[21] = '{1'b1,11'h031,1'b0,11'h000,8'h00,1'b1,1'b0,11'h020,16'h0000, 1'b1,1'b1,1'b1,11'h031,1'b0,11'h000,8'h00,1'b0,1'b1,8'h4C,16'h007B};
    vecs[22] = '{1'b0,11'h000,1'b0,11'h000,8'h00,1'b1,1'b0,11'h020,16'h0000, 1'b1,1'b1,1'b1,11'h020,1'b0,11'h000,8'h00,1'b0,1'b1,8'h4D,16'h007B};
    vecs[23] = '{1'b0,11'h000,1'b0,11'h000,8'h00,1'b1,1'b0,11'h020,16'h0000, 1'b1,1'b1,1'b0,11'h000,1'b0,11'h000,8'h00,1'b0,1'b0,8'h00,16'h007B};
    vecs[24] = '{1'b0,11'h000,1'b0,11'h000,8'h00,1'b1,1'b0,11'h020,16'h0000, 1'b1,1'b1,1'b0,11'h000,1'b0,11'h000,8'h00,1'b1,1'b0,8'h00,16'h005C};
    vecs[25] = '{1'b0,11'h000,1'b0,11'h000,8'h00,1'b0,1'b0,11'h000,16'h0000, 1'b1,1'b1,1'b0,11'h000,1'b0,11'h000,8'h00,1'b0,1'b0,8'h00,16'h005C};
    // bus write aborted in WR_REQ
    vecs[26] = '{1'b0,11'h000,1'b0,11'h000,8'h00,1'b1,1'b1,11'h050,16'h0077, 1'b1,1'b1,1'b0,11'h000,1'b0,11'h000,8'h00,1'b0,1'b0,8'h00,16'h005C};
    vecs[27] = '{1'b0,11'h000,1'b0,11'h000,8'h00,1'b0,1'b0,11'h000,16'h0000, 1'b1,1'b1,1'b0,11'h000,1'b0,11'h000,8'h00,1'b0,1'b0,8'h00,16'h005C};
    vecs[28] = '{1'b0,11'h000,1'b0,11'h000,8'h00,1'b0,1'b0,11'h000,16'h0000, 1'b1,1'b1,1'b0,11'h000,1'b0,11'h000,8'h00,1'b0,1'b0,8'h00,16'h005C};
    // bus write 0x060 delayed one cycle by a core write
    vecs[29] = '{1'b0,11'h000,1'b1,11'h1F0,8'h11,1'b1,1'b1,11'h060,16'hBEEF, 1'b1,1'b1,1'b0,11'h000,1'b1,11'h1F0,8'h11,1'b0,1'b0,8'h00,16'h005C};
    vecs[30] = '{1'b0,11'h000,1'b1,11'h1F1,8'h22,1'b1,1'b1,11'h060,16'hBEEF, 1'b1,1'b1,1'b0,11'h000,1'b1,11'h1F1,8'h22,1'b0,1'b0,8'h00,16'h005C};
    vecs[31] = '{1'b0,11'h000,1'b0,11'h000,8'h00,1'b1,1'b1,11'h060,16'hBEEF, 1'b1,1'b1,1'b0,11'h000,1'b1,11'h060,8'hEF,1'b0,1'b0,8'h00,16'h005C};
    vecs[32] = '{1'b0,11'h000,1'b0,11'h000,8'h00,1'b1,1'b1,11'h060,16'hBEEF, 1'b1,1'b1,1'b0,11'h000,1'b0,11'h000,8'h00,1'b1,1'b0,8'h00,16'h005C};
    vecs[33] = '{1'b0,11'h000,1'b0,11'h000,8'h00,1'b0,1'b0,11'h000,16'h0000, 1'b1,1'b1,1'b0,11'h000,1'b0,11'h000,8'h00,1'b0,1'b0,8'h00,16'h005C};

    drive_idle();
    repeat (3) @(negedge clk);
    #3;
    chk("reset_outs", outs_all(), 60'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #3;
      chk($sformatf("vec%0d", i), outs_masked(), exp_pack(vecs[i]));
    end

    // Core holds write requests while the bus writes 0x0AA.
    rdy_low = 0; gnt_cyc = -1; ack_cyc = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) begin
        core_wr_req = 1'b1; core_wr_addr = 11'h1F0; core_wr_data = 8'h11;
        bus_cyc = 1'b1; bus_we = 1'b1; bus_addr = 11'h0AA; bus_wdata = 16'h1234;
      end
      if (ack_cyc >= 0) bus_cyc = 1'b0;
      #3;
      if (!core_wr_rdy) rdy_low++;
      if (ram_we && ram_waddr == 11'h0AA && ram_wdata == 8'h34 && gnt_cyc < 0) gnt_cyc = c;
      if (bus_ack && ack_cyc < 0) ack_cyc = c;
    end
`ifdef USB_EP_BUF_ARB_STARVE_EN
    chk_int("starve_rdy_low_cycles", rdy_low, 1);
    chk_int("starve_grant_cycle", gnt_cyc, STARVE_MAX + 1);
    chk_int("starve_ack_cycle", ack_cyc, STARVE_MAX + 2);
`else
    chk_int("starve_rdy_low_cycles", rdy_low, 0);
    chk_int("starve_grant_cycle", gnt_cyc, -1);
    chk_int("starve_ack_cycle", ack_cyc, -1);
`endif
    @(negedge clk);
    drive_idle();
    #3;
    chk("abort_after_starve", {59'h0, ram_we | bus_ack}, 60'h0);

    // Reset asserted while the bus read sits in RD_DATA.
    @(negedge clk);
    bus_cyc = 1'b1; bus_we = 1'b0; bus_addr = 11'h060;
    #3;
    @(negedge clk);
    #3;
    @(negedge clk);
    core_rd_req = 1'b1; core_rd_addr = 11'h00A;
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_outs", outs_all(), 60'h0);
    @(negedge clk);
    drive_idle();
    #3;
    chk("rst_held_outs", outs_all(), 60'h0);
    @(negedge clk);
    rst = 1'b0;
    n_ack = 0; n_ren = 0;
    for (int c = 0; c < 4; c++) begin
      #3;
      if (bus_ack) n_ack++;
      if (ram_ren) n_ren++;
      @(negedge clk);
    end
    chk_int("post_rst_no_ack_no_ren", n_ack + n_ren, 0);

    // Next transaction completes normally: bus read 0x041 -> 0x3D.
    bus_cyc = 1'b1; bus_we = 1'b0; bus_addr = 11'h041;
    ack_cyc = -1; ren_cyc = -1; n_ack = 0; got_rdata = 16'h0000;
    for (int c = 0; c < 8; c++) begin
      #3;
      if (ram_ren && ram_raddr == 11'h041 && ren_cyc < 0) ren_cyc = c;
      if (bus_ack) begin
        n_ack++;
        if (ack_cyc < 0) begin
          ack_cyc = c;
          got_rdata = bus_rdata;
        end
      end
      @(negedge clk);
      if (ack_cyc >= 0) bus_cyc = 1'b0;
    end
    chk_int("post_rst_read_ren_cycle", ren_cyc, 1);
    chk_int("post_rst_read_ack_cycle", ack_cyc, 3);
    chk_int("post_rst_read_ack_count", n_ack, 1);
    chk("post_rst_read_data", {44'h0, got_rdata}, 60'h00000000000003D);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
